// File: rtl/reg_dump_ctrl.sv
// ============================================================================
// reg_dump_ctrl
// ----------------------------------------------------------------------------
// Sequential register-file reader. On start it walks rf_addr 0..R-1,
// captures each value from the reg_file rs read port and streams the
// values out one word per beat on a valid/ready interface. It is used for
// end-of-program state dumps and for register checks.
//
// Optional feature (compile-time macro REG_DUMP_CSUM_EN):
//   When defined, one extra beat follows beat R-1. That beat carries the sum
//   of all R words mod 2^W, with dout_idx = all ones and dout_last = 1.
//   R must be <= 2^AW-1 so that the checksum index cannot alias a register.
//   When undefined, there is no checksum state or register, and dout_last is
//   set on beat R-1.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   begin dump (sampled only in IDLE)
//   abort        in   1   cancel a dump in progress
//   rf_addr      out  AW  registered address to the reg_file rs read port
//   rf_data      in   W   rs read data (combinational from rf_addr)
//   dout         out  W   beat data
//   dout_idx     out  AW  register index of the current beat
//   dout_valid   out  1   beat valid
//   dout_ready   in   1   sink accepts beat
//   dout_last    out  1   final beat of the dump
//   busy         out  1   high in every state except IDLE
//   done         out  1   one-cycle pulse after the final beat is accepted
//   dbg_state_o  out  3   current FSM state (debug visibility)
//
// Handshake: a beat transfers on a rising edge where dout_valid & dout_ready
// are both high. While dout_valid is high, dout, dout_idx and dout_last stay
// constant until that transfer. dout_valid drops without a transfer only on
// abort or reset. If abort and a transfer coincide, the beat counts as not
// delivered.
// ============================================================================
module reg_dump_ctrl #(
    parameter int R  = 12,
    parameter int W  = 9,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rf_addr,
    input  logic [W-1:0]  rf_data,
    output logic [W-1:0]  dout,
    output logic [AW-1:0] dout_idx,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
`ifdef REG_DUMP_CSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd3;
`endif
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [AW-1:0] LAST_IDX = AW'(R - 1);

    logic [2:0]    state_q, state_d;
    // The read index also serves as the registered rf_addr.
    logic [AW-1:0] idx_q, idx_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [AW-1:0] dout_idx_q, dout_idx_d;
    logic          last_q, last_d;
`ifdef REG_DUMP_CSUM_EN
    logic [W-1:0]  csum_q, csum_d;
`endif

    // Abort only applies while a dump is moving words.
    logic in_dump;
`ifdef REG_DUMP_CSUM_EN
    assign in_dump = (state_q == ST_READ) || (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
    assign in_dump = (state_q == ST_READ) || (state_q == ST_SEND);
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dout_d     = dout_q;
        dout_idx_d = dout_idx_q;
        last_d     = last_q;
`ifdef REG_DUMP_CSUM_EN
        csum_d     = csum_q;
`endif

        if (in_dump && abort) begin
            // Abort wins over a same-cycle handshake.
            state_d = ST_IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_d   = '0;
                        last_d  = 1'b0;
`ifdef REG_DUMP_CSUM_EN
                        csum_d  = '0;
`endif
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    dout_d     = rf_data;
                    dout_idx_d = idx_q;
`ifdef REG_DUMP_CSUM_EN
                    csum_d     = csum_q + rf_data;
                    last_d     = 1'b0;
`else
                    last_d     = (idx_q == LAST_IDX);
`endif
                    state_d    = ST_SEND;
                end
                ST_SEND: begin
                    if (dout_ready) begin
                        if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CSUM_EN
                            // csum_q already includes word R-1 (added in READ).
                            dout_d     = csum_q;
                            dout_idx_d = '1;
                            last_d     = 1'b1;
                            state_d    = ST_CSUM;
`else
                            state_d    = ST_DONE;
`endif
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_READ;
                        end
                    end
                end
`ifdef REG_DUMP_CSUM_EN
                ST_CSUM: begin
                    if (dout_ready) begin
                        state_d = ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    idx_d   = '0;
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    idx_d   = '0;
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            dout_q     <= '0;
            dout_idx_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dout_q     <= dout_d;
            dout_idx_q <= dout_idx_d;
            last_q     <= last_d;
        end
    end

`ifdef REG_DUMP_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign rf_addr     = idx_q;
    assign dout        = dout_q;
    assign dout_idx    = dout_idx_q;
    assign dout_last   = last_q;
`ifdef REG_DUMP_CSUM_EN
    assign dout_valid  = (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
    assign dout_valid  = (state_q == ST_SEND);
`endif
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// ============================================================================
// tb_reg_dump_ctrl
// Directed bench for reg_dump_ctrl. Stimulus pushes the expected beats
// {last, idx, data} into exp_q; a negedge monitor pops one entry per accepted
// beat and compares. Directed code checks timing, abort, reset and done.
// ============================================================================
module tb_reg_dump_ctrl;

    localparam int R  = 12;
    localparam int W  = 9;
    localparam int AW = 4;
    localparam int BW = W + AW + 1;
`ifdef REG_DUMP_CSUM_EN
    localparam int DUMP_CYC   = 2 * R + 2;
    localparam int DUMP_BEATS = R + 1;
`else
    localparam int DUMP_CYC   = 2 * R + 1;
    localparam int DUMP_BEATS = R;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dout_ready = 1'b1;
    logic [AW-1:0] rf_addr;
    logic [W-1:0]  rf_data;
    logic [W-1:0]  dout;
    logic [AW-1:0] dout_idx;
    logic          dout_valid;
    logic          dout_last;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    logic [W-1:0] regs [16];
    assign rf_data = regs[rf_addr];

    reg_dump_ctrl #(.R(R), .W(W), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .dout        (dout),
        .dout_idx    (dout_idx),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    logic [BW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    logic [BW-1:0] prev_beat = '0;
    logic          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && dout_valid)
                check("stable_beat", 32'({dout_last, dout_idx, dout}), 32'(prev_beat));
            if (dout_valid && dout_ready && !abort) begin
                beat_cnt <= beat_cnt + 1;
                if (exp_q.size() == 0) flag("unexpected_beat");
                else check("beat", 32'({dout_last, dout_idx, dout}), 32'(exp_q.pop_front()));
            end
            if (done) done_cnt <= done_cnt + 1;
            prev_stall <= dout_valid && !dout_ready && !abort;
            prev_beat  <= {dout_last, dout_idx, dout};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        logic [W-1:0] sum;
        sum = '0;
        for (int i = 0; i < R; i++) begin
`ifdef REG_DUMP_CSUM_EN
            exp_q.push_back({1'b0, AW'(i), regs[i]});
`else
            exp_q.push_back({(i == R - 1), AW'(i), regs[i]});
`endif
            sum = sum + regs[i];
        end
`ifdef REG_DUMP_CSUM_EN
        exp_q.push_back({1'b1, {AW{1'b1}}, sum});
`endif
    endtask

    task automatic pulse_start(output int t0);
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idx(input int k);
        for (int i = 0; i < 200; i++) begin
            if (dout_valid && (dout_idx == AW'(k))) return;
            tick();
        end
        flag("wait_idx_timeout");
    endtask

    task automatic wait_done(output int t);
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                t = cyc;
                return;
            end
            tick();
        end
        t = cyc;
        flag("done_timeout");
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_valid"}, 32'(dout_valid), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_rf_addr"}, 32'(rf_addr), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0, td, bc, dc;
        for (int i = 0; i < 16; i++) regs[i] = '0;

        // Reset state
        #23;
        check_idle("reset");
        check("reset_dout", 32'(dout), 0);
        check("reset_idx", 32'(dout_idx), 0);
        check("reset_last", 32'(dout_last), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("idle_abort");

        // 1: regs[i]=i+1, ready held high
        for (int i = 0; i < R; i++) regs[i] = W'(i + 1);
        push_dump();
        bc = beat_cnt;
        pulse_start(t0);
        check("first_beat_not_yet", 32'(dout_valid), 0);
        tick();
        check("first_valid_latency", 32'(dout_valid), 1);
        wait_done(td);
        check("t1_done_latency", 32'(td - t0), 32'(DUMP_CYC));
        tick();
        check("t1_busy_after", 32'(busy), 0);
        check("t1_done_one_cycle", 32'(done), 0);
        check("t1_beats", 32'(beat_cnt - bc), 32'(DUMP_BEATS));
        check("t1_queue_empty", 32'(exp_q.size()), 0);

        // 2: stall beat 5 for 3 cycles
        push_dump();
        pulse_start(t0);
        wait_idx(5);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", 32'(dout_valid), 1);
            check("t2_hold_dout", 32'(dout), 6);
            check("t2_hold_idx", 32'(dout_idx), 5);
            check("t2_hold_rf_addr", 32'(rf_addr), 5);
        end
        dout_ready = 1'b1;
        tick();
        check("t2_gap", 32'(dout_valid), 0);
        tick();
        check("t2_next_valid", 32'(dout_valid), 1);
        check("t2_next_idx", 32'(dout_idx), 6);
        wait_done(td);
        tick();
        check("t2_queue_empty", 32'(exp_q.size()), 0);

        // 3: abort during SEND of idx 4 with ready high
        push_dump();
        pulse_start(t0);
        wait_idx(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("t3_abort");
        check("t3_queue_left", 32'(exp_q.size()), 32'(DUMP_BEATS - 4));
        exp_q.delete();
        dc = done_cnt;
        bc = beat_cnt;
        repeat (30) tick();
        check("t3_no_done", 32'(done_cnt), 32'(dc));
        check("t3_no_beats", 32'(beat_cnt), 32'(bc));

        // 4: start re-pulsed mid-dump is ignored
        push_dump();
        bc = beat_cnt;
        pulse_start(t0);
        wait_idx(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(td);
        check("t4_done_latency", 32'(td - t0), 32'(DUMP_CYC));
        tick();
        check("t4_beats", 32'(beat_cnt - bc), 32'(DUMP_BEATS));
        check("t4_busy_after", 32'(busy), 0);

        // 5: asynchronous reset at idx 7
        push_dump();
        pulse_start(t0);
        wait_idx(7);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t5_reset");
        check("t5_dout", 32'(dout), 0);
        check("t5_idx", 32'(dout_idx), 0);
        check("t5_last", 32'(dout_last), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        push_dump();
        bc = beat_cnt;
        pulse_start(t0);
        tick();
        check("t5_restart_idx", 32'(dout_idx), 0);
        wait_done(td);
        check("t5_done_latency", 32'(td - t0), 32'(DUMP_CYC));
        tick();
        check("t5_beats", 32'(beat_cnt - bc), 32'(DUMP_BEATS));

        // 6: all registers 9'h1FF (checksum 9'h1F4 when enabled)
        for (int i = 0; i < R; i++) regs[i] = 9'h1FF;
        push_dump();
        pulse_start(t0);
        wait_done(td);
        check("t6_done_latency", 32'(td - t0), 32'(DUMP_CYC));
        tick();
        check("t6_queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
